// File: rtl/aes_gcm_pkg.sv
// Shared GCM types and GF(2^128) helpers. Vectors are [0:127], index 0 is the first GCM bit (MSB).
package aes_gcm_pkg;

    typedef enum logic [1:0] {
        PH_AAD  = 2'd0,
        PH_CT   = 2'd1,
        PH_LEN  = 2'd2,
        PH_RSVD = 2'd3
    } gcm_phase_e;

    localparam logic [0:127] GF128_R = 128'hE1 << 120;

    // GCM "rightshift" moves bit i to i+1; a bit falling off index 127 folds back via R.
    function automatic logic [0:127] gf128_shift_reduce(input logic [0:127] v);
        gf128_shift_reduce = v[127] ? ((v >> 1) ^ GF128_R) : (v >> 1);
    endfunction

endpackage

// File: rtl/gf128_digit_mul.sv
// Combinational GF(2^128) digit step: folds DIGIT_BITS bits of X into Z, advancing V per bit.
module gf128_digit_mul
    import aes_gcm_pkg::*;
#(
    parameter int unsigned DIGIT_BITS = 8
) (
    input  logic [0:127]            i_z,
    input  logic [0:127]            i_v,
    input  logic [0:DIGIT_BITS-1]   i_x,
    output logic [0:127]            o_z,
    output logic [0:127]            o_v
);

    always_comb begin
        o_z = i_z;
        o_v = i_v;
        for (int unsigned j = 0; j < DIGIT_BITS; j++) begin
            if (i_x[j]) begin
                o_z = o_z ^ o_v;
            end
            o_v = gf128_shift_reduce(o_v);
        end
    end

endmodule

// File: rtl/aes_ghash_stage.sv
// GHASH accumulator and tag generator behind a digit-serial multiplier with ready/valid intake.
module aes_ghash_stage
    import aes_gcm_pkg::*;
#(
    parameter int unsigned DIGIT_BITS = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic           i_new_instance,
    input  logic [1:0]     i_phase,
    input  logic [0:127]   i_block,
    input  logic [0:127]   i_h,
    input  logic [0:127]   i_ej0,
    output logic [0:127]   o_ghash,
    output logic [0:127]   o_tag,
    output logic           o_tag_valid,
    output logic           o_err
);

    localparam int unsigned N_STEPS   = 128 / DIGIT_BITS;
    localparam logic [7:0]  LAST_STEP = 8'(N_STEPS - 1);

    typedef enum logic {StIdle, StMult} state_e;

    state_e       state_q, state_d;
    gcm_phase_e   phase_q, phase_d;
    logic [0:127] h_q, h_d, ej0_q, ej0_d, acc_q, acc_d;
    logic [0:127] x_q, x_d, z_q, z_d, v_q, v_d, tag_q, tag_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         tag_valid_q, tag_valid_d, err_q, err_d;
    logic [0:127] z_nxt, v_nxt;

    // X is shifted toward index 0 each step so the current digit is always its leading slice.
    gf128_digit_mul #(
        .DIGIT_BITS (DIGIT_BITS)
    ) u_mul (
        .i_z (z_q),
        .i_v (v_q),
        .i_x (x_q[0:DIGIT_BITS-1]),
        .o_z (z_nxt),
        .o_v (v_nxt)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        h_d         = h_q;
        ej0_d       = ej0_q;
        acc_d       = acc_q;
        x_d         = x_q;
        z_d         = z_q;
        v_d         = v_q;
        tag_d       = tag_q;
        cnt_d       = cnt_q;
        tag_valid_d = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    if (gcm_phase_e'(i_phase) == PH_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        x_d     = (i_new_instance ? '0 : acc_q) ^ i_block;
                        h_d     = i_new_instance ? i_h : h_q;
                        ej0_d   = i_new_instance ? i_ej0 : ej0_q;
                        v_d     = i_new_instance ? i_h : h_q;
                        z_d     = '0;
                        phase_d = gcm_phase_e'(i_phase);
                        cnt_d   = '0;
                        state_d = StMult;
                    end
                end
            end
            StMult: begin
                z_d   = z_nxt;
                v_d   = v_nxt;
                x_d   = x_q << DIGIT_BITS;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d = StIdle;
                    if (phase_q == PH_LEN) begin
                        acc_d       = '0;
                        tag_d       = z_nxt ^ ej0_q;
                        tag_valid_d = 1'b1;
                    end else begin
                        acc_d = z_nxt;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= PH_AAD;
            h_q         <= '0;
            ej0_q       <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            z_q         <= '0;
            v_q         <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            tag_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            h_q         <= h_d;
            ej0_q       <= ej0_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            z_q         <= z_d;
            v_q         <= v_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            tag_valid_q <= tag_valid_d;
            err_q       <= err_d;
        end
    end

    assign o_ready     = (state_q == StIdle);
    assign o_ghash     = acc_q;
    assign o_tag       = tag_q;
    assign o_tag_valid = tag_valid_q;
    assign o_err       = err_q;

endmodule
